// File: rtl/reorder_buffer_pkg.sv
// ============================================================================
// reorder_buffer_pkg: shared sizes, entry record and index helper for the ROB.
// Revision: 1.0
// ============================================================================
`default_nettype none

package reorder_buffer_pkg;

  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int PREG_W = 6;
  localparam int AREG_W = 5;

  // Also used by rename to mark "no physical destination".
  localparam logic [PREG_W-1:0] INVALID_PREG = 6'h3F;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_dest;
    logic [AREG_W-1:0] arch_rd;
    logic [PREG_W-1:0] phys_rd;
  } rob_entry_t;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reorder_buffer_if.sv
// ============================================================================
// rob_if: allocate / complete / retire signal bundle of the reorder buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rob_if;
  import reorder_buffer_pkg::*;

  logic              alloc_valid;
  logic              alloc_has_dest;
  logic [AREG_W-1:0] alloc_arch_rd;
  logic [PREG_W-1:0] alloc_phys_rd;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_rob_idx;
  logic              cmpl0_valid;
  logic [IDX_W-1:0]  cmpl0_rob_idx;
  logic              cmpl1_valid;
  logic [IDX_W-1:0]  cmpl1_rob_idx;
  logic              commit_valid;
  logic              retire_valid;
  logic [PREG_W-1:0] retire_phys_reg;
  logic [AREG_W-1:0] retire_arch_rd;
  logic [IDX_W:0]    rob_count;
  logic              rob_empty;

  modport slave (
    input  alloc_valid, alloc_has_dest, alloc_arch_rd, alloc_phys_rd,
    input  cmpl0_valid, cmpl0_rob_idx, cmpl1_valid, cmpl1_rob_idx,
    output alloc_ready, alloc_rob_idx, commit_valid, retire_valid,
    output retire_phys_reg, retire_arch_rd, rob_count, rob_empty
  );

  modport master (
    output alloc_valid, alloc_has_dest, alloc_arch_rd, alloc_phys_rd,
    output cmpl0_valid, cmpl0_rob_idx, cmpl1_valid, cmpl1_rob_idx,
    input  alloc_ready, alloc_rob_idx, commit_valid, retire_valid,
    input  retire_phys_reg, retire_arch_rd, rob_count, rob_empty
  );

endinterface

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
// reorder_buffer: in-order retirement buffer; allocates at tail, marks done
// from two completion ports, retires the oldest done entry once per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  rob_if.slave  rob
);

  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

  rob_entry_t        entries_q [DEPTH];
  rob_entry_t        entries_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              commit_q, commit_d;
  logic              retv_q, retv_d;
  logic [PREG_W-1:0] rphys_q, rphys_d;
  logic [AREG_W-1:0] rarch_q, rarch_d;
  logic              alloc_fire;
  logic              retire_fire;

  assign alloc_fire  = rob.alloc_valid && (count_q != FULL_COUNT);
  assign retire_fire = entries_q[head_q].valid && entries_q[head_q].done;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    commit_d  = 1'b0;
    retv_d    = 1'b0;
    rphys_d   = rphys_q;
    rarch_d   = rarch_q;

    if (retire_fire) begin
      entries_d[head_q].valid = 1'b0;
      entries_d[head_q].done  = 1'b0;
      head_d   = idx_inc(head_q);
      commit_d = 1'b1;
      retv_d   = entries_q[head_q].has_dest;
      rphys_d  = entries_q[head_q].phys_rd;
      rarch_d  = entries_q[head_q].arch_rd;
    end

    // Validity is checked after the retire clear so a late completion
    // aimed at the retiring head cannot resurrect it.
    if (rob.cmpl0_valid && entries_d[rob.cmpl0_rob_idx].valid)
      entries_d[rob.cmpl0_rob_idx].done = 1'b1;
    if (rob.cmpl1_valid && entries_d[rob.cmpl1_rob_idx].valid)
      entries_d[rob.cmpl1_rob_idx].done = 1'b1;

    if (alloc_fire) begin
      entries_d[tail_q] = '{valid:    1'b1,
                            done:     1'b0,
                            has_dest: rob.alloc_has_dest,
                            arch_rd:  rob.alloc_arch_rd,
                            phys_rd:  rob.alloc_phys_rd};
      tail_d = idx_inc(tail_q);
    end

    case ({alloc_fire, retire_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      commit_q <= 1'b0;
      retv_q   <= 1'b0;
      rphys_q  <= '0;
      rarch_q  <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      commit_q  <= commit_d;
      retv_q    <= retv_d;
      rphys_q   <= rphys_d;
      rarch_q   <= rarch_d;
    end
  end

  assign rob.alloc_ready     = (count_q != FULL_COUNT);
  assign rob.alloc_rob_idx   = tail_q;
  assign rob.commit_valid    = commit_q;
  assign rob.retire_valid    = retv_q;
  assign rob.retire_phys_reg = rphys_q;
  assign rob.retire_arch_rd  = rarch_q;
  assign rob.rob_count       = count_q;
  assign rob.rob_empty       = (count_q == '0);

endmodule

`default_nettype wire
